// File: rtl/cv32e40p_pkg.sv
// Shared types for the TMR fault monitor: FSM state encoding and the event record layout.
package cv32e40p_pkg;

  // Record field widths match the monitor's default geometry (4 sources, 16-bit timestamp).
  localparam int TMR_NUM_SOURCES = 4;
  localparam int TMR_CNT_WIDTH   = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MONITOR = 2'd1,
    ALARM   = 2'd2
  } tmr_state_e;

  typedef struct packed {
    logic [TMR_NUM_SOURCES-1:0] mask;
    logic [TMR_CNT_WIDTH-1:0]   tstamp;
  } tmr_evt_t;

endpackage

// File: rtl/cv32e40p_tmr_evt_fifo.sv
// Shift-register event FIFO; entry 0 is always the head, so the read data is a plain register.
module cv32e40p_tmr_evt_fifo
  import cv32e40p_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type rec_t = tmr_evt_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  rec_t wdata,
  output rec_t rdata,
  output logic full,
  output logic empty
);

  localparam int CW = $clog2(DEPTH) + 1;

  rec_t           mem_q [DEPTH];
  rec_t           mem_d [DEPTH];
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic [CW-1:0]  wr_idx;
  logic           do_pop;
  logic           do_push;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[0];

  // Vacated slots are refilled with zero so an empty FIFO presents an all-zero head.
  always_comb begin
    mem_d  = mem_q;
    wr_idx = cnt_q - CW'(do_pop);
    cnt_d  = cnt_q + CW'(do_push) - CW'(do_pop);
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
      mem_d[DEPTH-1] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && (wr_idx == CW'(i))) mem_d[i] = wdata;
    end
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cv32e40p_tmr_fault_monitor.sv
// Collects TMR voter mismatch flags into timestamped event records, sticky/persistent flags and an alarm FSM.
//   state   | meaning
//   IDLE    | monitoring disabled or just cleared
//   MONITOR | enabled, no persistent source seen
//   ALARM   | a source stayed faulty long enough; left only via clear_i
module cv32e40p_tmr_fault_monitor
  import cv32e40p_pkg::*;
#(
  parameter int NUM_SOURCES    = TMR_NUM_SOURCES,
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_WIDTH      = TMR_CNT_WIDTH,
  parameter int PERSIST_THRESH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable_i,
  input  logic [NUM_SOURCES-1:0] faulty_i,
  input  logic                   clear_i,
  output logic                   evt_valid_o,
  input  logic                   evt_ready_i,
  output logic [NUM_SOURCES-1:0] evt_mask_o,
  output logic [CNT_WIDTH-1:0]   evt_time_o,
  output logic [NUM_SOURCES-1:0] sticky_o,
  output logic [CNT_WIDTH-1:0]   fault_cnt_o,
  output logic [NUM_SOURCES-1:0] persistent_o,
  output logic                   overflow_o,
  output logic                   alarm_o
);

  localparam int RW = $clog2(PERSIST_THRESH + 1);

  tmr_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]   ts_q;
  logic [CNT_WIDTH-1:0]   fault_cnt_q;
  logic [NUM_SOURCES-1:0] prev_q;
  logic [NUM_SOURCES-1:0] sticky_q;
  logic [NUM_SOURCES-1:0] persist_q;
  logic [NUM_SOURCES-1:0] persist_d;
  logic [RW-1:0]          run_q [NUM_SOURCES];
  logic [RW-1:0]          run_d [NUM_SOURCES];
  logic                   ovf_q;
  logic                   capture;
  logic                   pop;
  logic                   full;
  logic                   empty;
  tmr_evt_t               push_rec;
  tmr_evt_t               head_rec;

  // A capture fires on every change to a non-zero mask, not on every faulty cycle.
  assign capture  = enable_i && (faulty_i != '0) && (faulty_i != prev_q) && !clear_i;
  assign pop      = !empty && evt_ready_i;
  assign push_rec = '{mask: faulty_i, tstamp: ts_q};

  cv32e40p_tmr_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .rec_t (tmr_evt_t)
  ) u_evt_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear_i),
    .push  (capture),
    .pop   (pop),
    .wdata (push_rec),
    .rdata (head_rec),
    .full  (full),
    .empty (empty)
  );

  assign evt_valid_o  = !empty;
  assign evt_mask_o   = head_rec.mask;
  assign evt_time_o   = head_rec.tstamp;
  assign sticky_o     = sticky_q;
  assign fault_cnt_o  = fault_cnt_q;
  assign persistent_o = persist_q;
  assign overflow_o   = ovf_q;

  always_comb begin
    persist_d = persist_q;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      run_d[i] = '0;
      if (enable_i && faulty_i[i]) begin
        run_d[i] = (run_q[i] == RW'(PERSIST_THRESH)) ? run_q[i] : run_q[i] + RW'(1);
      end
      if (run_d[i] == RW'(PERSIST_THRESH)) persist_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q        <= '0;
      fault_cnt_q <= '0;
      prev_q      <= '0;
      sticky_q    <= '0;
      persist_q   <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < NUM_SOURCES; i++) run_q[i] <= '0;
    end else begin
      ts_q <= ts_q + CNT_WIDTH'(1);
      if (clear_i) begin
        fault_cnt_q <= '0;
        prev_q      <= '0;
        sticky_q    <= '0;
        persist_q   <= '0;
        ovf_q       <= 1'b0;
        for (int i = 0; i < NUM_SOURCES; i++) run_q[i] <= '0;
      end else begin
        prev_q    <= faulty_i;
        persist_q <= persist_d;
        for (int i = 0; i < NUM_SOURCES; i++) run_q[i] <= run_d[i];
        if (capture) begin
          sticky_q <= sticky_q | faulty_i;
          if (fault_cnt_q != '1) fault_cnt_q <= fault_cnt_q + CNT_WIDTH'(1);
          if (full && !pop) ovf_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i) state_d = MONITOR;
      MONITOR: begin
        if (!enable_i)            state_d = IDLE;
        else if (persist_d != '0) state_d = ALARM;
      end
      ALARM:   state_d = ALARM;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  always_comb begin
    alarm_o = 1'b0;
    if (state_q == ALARM) alarm_o = 1'b1;
  end

endmodule

// File: tb/tb_cv32e40p_tmr_fault_monitor.sv
// Directed bench for the TMR fault monitor with a queue-based reference model checked every cycle.
module tb_cv32e40p_tmr_fault_monitor;

  logic        clk;
  logic        rst_n;
  logic        enable_i;
  logic [3:0]  faulty_i;
  logic        clear_i;
  logic        evt_valid_o;
  logic        evt_ready_i;
  logic [3:0]  evt_mask_o;
  logic [15:0] evt_time_o;
  logic [3:0]  sticky_o;
  logic [15:0] fault_cnt_o;
  logic [3:0]  persistent_o;
  logic        overflow_o;
  logic        alarm_o;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  // reference model state
  logic [3:0] q_m[$];
  int         q_t[$];
  int         m_ts;
  int         m_cnt;
  int         m_state;  // 0 idle, 1 monitor, 2 alarm
  int         m_run[4];
  logic [3:0] m_prev;
  logic [3:0] m_sticky;
  logic [3:0] m_pers;
  bit         m_ovf;

  cv32e40p_tmr_fault_monitor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable_i),
    .faulty_i     (faulty_i),
    .clear_i      (clear_i),
    .evt_valid_o  (evt_valid_o),
    .evt_ready_i  (evt_ready_i),
    .evt_mask_o   (evt_mask_o),
    .evt_time_o   (evt_time_o),
    .sticky_o     (sticky_o),
    .fault_cnt_o  (fault_cnt_o),
    .persistent_o (persistent_o),
    .overflow_o   (overflow_o),
    .alarm_o      (alarm_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    q_t.delete();
    m_ts = 0; m_cnt = 0; m_state = 0; m_prev = '0;
    m_sticky = '0; m_pers = '0; m_ovf = 1'b0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
  endtask

  task automatic model_update(input logic en, input logic [3:0] f, input logic cl, input logic rdy);
    bit do_pop;
    bit do_cap;
    if (cl) begin
      int ts_keep;
      ts_keep = m_ts;
      model_reset();
      m_ts = ts_keep;
    end else begin
      do_pop = (q_m.size() > 0) && rdy;
      do_cap = en && (f != 4'd0) && (f != m_prev);
      if (do_pop) begin
        void'(q_m.pop_front());
        void'(q_t.pop_front());
      end
      if (do_cap) begin
        if (q_m.size() < 4) begin
          q_m.push_back(f);
          q_t.push_back(m_ts);
        end else begin
          m_ovf = 1'b1;
        end
        if (m_cnt < 65535) m_cnt++;
        m_sticky = m_sticky | f;
      end
      for (int i = 0; i < 4; i++) begin
        if (en && f[i]) m_run[i] = (m_run[i] < 3) ? m_run[i] + 1 : 3;
        else            m_run[i] = 0;
        if (m_run[i] == 3) m_pers[i] = 1'b1;
      end
      case (m_state)
        0: if (en) m_state = 1;
        1: if (!en) m_state = 0; else if (m_pers != 4'd0) m_state = 2;
        default: m_state = 2;
      endcase
      m_prev = f;
    end
    m_ts = (m_ts + 1) % 65536;
  endtask

  // Called at negedge+1; returns at the following negedge+1.
  task automatic step(input logic en, input logic [3:0] f, input logic cl, input logic rdy);
    enable_i    = en;
    faulty_i    = f;
    clear_i     = cl;
    evt_ready_i = rdy;
    model_update(en, f, cl, rdy);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("valid", 32'(evt_valid_o), 32'(q_m.size() != 0));
      chk("mask", 32'(evt_mask_o), (q_m.size() != 0) ? 32'(q_m[0]) : 32'd0);
      chk("time", 32'(evt_time_o), (q_t.size() != 0) ? 32'(q_t[0]) : 32'd0);
      chk("fault_cnt", 32'(fault_cnt_o), 32'(m_cnt));
      chk("sticky", 32'(sticky_o), 32'(m_sticky));
      chk("persistent", 32'(persistent_o), 32'(m_pers));
      chk("overflow", 32'(overflow_o), 32'(m_ovf));
      chk("alarm", 32'(alarm_o), 32'(m_state == 2));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_order [4];
    rst_n = 1'b0; enable_i = 1'b0; faulty_i = '0; clear_i = 1'b0; evt_ready_i = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(evt_valid_o), 32'd0);
    chk("rst_cnt", 32'(fault_cnt_o), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // single event at timestamp 10
    repeat (10) step(1'b1, 4'b0000, 1'b0, 1'b1);
    step(1'b1, 4'b0001, 1'b0, 1'b1);
    chk("s1_valid", 32'(evt_valid_o), 32'd1);
    chk("s1_mask", 32'(evt_mask_o), 32'h1);
    chk("s1_time", 32'(evt_time_o), 32'd10);
    chk("s1_cnt", 32'(fault_cnt_o), 32'd1);
    chk("s1_sticky", 32'(sticky_o), 32'h1);
    chk("s1_pers", 32'(persistent_o), 32'h0);
    step(1'b1, 4'b0000, 1'b0, 1'b1);
    chk("s1_popped", 32'(evt_valid_o), 32'd0);

    // persistent source
    repeat (3) step(1'b1, 4'b0100, 1'b0, 1'b1);
    chk("s2_pers", 32'(persistent_o), 32'h4);
    chk("s2_alarm", 32'(alarm_o), 32'd1);
    chk("s2_cnt", 32'(fault_cnt_o), 32'd2);
    repeat (2) step(1'b0, 4'b0000, 1'b0, 1'b1);
    chk("s2_alarm_hold", 32'(alarm_o), 32'd1);
    step(1'b0, 4'b0000, 1'b1, 1'b0);
    chk("s2_alarm_clr", 32'(alarm_o), 32'd0);
    chk("s2_pers_clr", 32'(persistent_o), 32'h0);

    // FIFO full with overflow
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    step(1'b1, 4'b0010, 1'b0, 1'b0);
    step(1'b1, 4'b0011, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 1'b0, 1'b0);
    step(1'b1, 4'b1000, 1'b0, 1'b0);
    chk("s3_ovf", 32'(overflow_o), 32'd1);
    chk("s3_cnt", 32'(fault_cnt_o), 32'd5);
    chk("s3_head", 32'(evt_mask_o), 32'h1);
    chk("s3_sticky", 32'(sticky_o), 32'hf);
    step(1'b1, 4'b0000, 1'b1, 1'b0);

    // full FIFO with simultaneous push and pop
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    step(1'b1, 4'b0010, 1'b0, 1'b0);
    step(1'b1, 4'b0011, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 1'b0, 1'b0);
    chk("s4_head0", 32'(evt_mask_o), 32'h1);
    step(1'b1, 4'b1000, 1'b0, 1'b1);
    chk("s4_ovf", 32'(overflow_o), 32'd0);
    chk("s4_cnt", 32'(fault_cnt_o), 32'd5);
    exp_order[0] = 4'b0010; exp_order[1] = 4'b0011;
    exp_order[2] = 4'b0100; exp_order[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      chk("s4_order", 32'(evt_mask_o), 32'(exp_order[i]));
      step(1'b1, 4'b0000, 1'b0, 1'b1);
    end
    chk("s4_drained", 32'(evt_valid_o), 32'd0);

    // clear beats a simultaneous capture
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    step(1'b1, 4'b0010, 1'b1, 1'b0);
    chk("s5_valid", 32'(evt_valid_o), 32'd0);
    chk("s5_cnt", 32'(fault_cnt_o), 32'd0);
    chk("s5_sticky", 32'(sticky_o), 32'h0);
    chk("s5_ovf", 32'(overflow_o), 32'd0);
    step(1'b1, 4'b0010, 1'b0, 1'b0);
    chk("s5_recapture", 32'(fault_cnt_o), 32'd1);

    // mid-operation reset with two pending records
    step(1'b1, 4'b0100, 1'b0, 1'b0);
    chk("s6_cnt_pre", 32'(fault_cnt_o), 32'd2);
    evt_ready_i = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("s6_valid", 32'(evt_valid_o), 32'd0);
    chk("s6_cnt", 32'(fault_cnt_o), 32'd0);
    chk("s6_state", 32'(dut.state_q), 32'(cv32e40p_pkg::IDLE));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    chk("s6_after_time", 32'(evt_time_o), 32'd0);
    step(1'b1, 4'b0000, 1'b0, 1'b1);
    step(1'b0, 4'b0000, 1'b0, 1'b1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cv32e40p_tmr_fault_monitor.md
CV32E40P_TMR_FAULT_MONITOR -- requirements
Module: cv32e40p_tmr_fault_monitor

Interface
REQ-001 Parameter NUM_SOURCES, default 4: number of voter faulty flags monitored.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two >= 2: event-record buffer depth.
REQ-003 Parameter CNT_WIDTH, default 16: width of the total-event counter and the timestamp.
REQ-004 Parameter PERSIST_THRESH, default 3, >= 2: consecutive faulty cycles that mark a source as persistent.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 enable_i  in  1  monitoring enable.
REQ-008 faulty_i  in  NUM_SOURCES  per-voter mismatch flags; bit i is voter i's faulty_o.
REQ-009 clear_i  in  1  synchronous clear of counters, sticky flags, FIFO and FSM.
REQ-010 evt_valid_o  out  1  head event record available.
REQ-011 evt_ready_i  in  1  reader accepts the head record.
REQ-012 evt_mask_o  out  NUM_SOURCES  head record source mask.
REQ-013 evt_time_o  out  CNT_WIDTH  head record timestamp.
REQ-014 sticky_o  out  NUM_SOURCES  bit i set once source i has been faulty.
REQ-015 fault_cnt_o  out  CNT_WIDTH  saturating count of captured events.
REQ-016 persistent_o  out  NUM_SOURCES  bit i set once source i reaches the persistence threshold.
REQ-017 overflow_o  out  1  sticky flag: an event was dropped because the FIFO was full.
REQ-018 alarm_o  out  1  high while the FSM is in ALARM.

Function
REQ-019 Free-running timestamp counter: increments every cycle, wraps from all-ones to 0, and is unaffected by enable_i and clear_i.
REQ-020 Capture condition: enable_i=1, faulty_i != 0, and faulty_i differs from the faulty_i sampled in the previous cycle.
REQ-021 Capture action: push {faulty_i, timestamp}, increment fault_cnt_o, OR faulty_i into sticky_o.
REQ-022 fault_cnt_o saturates at all-ones.
REQ-023 Push with FIFO full and no pop in the same cycle: record dropped, overflow_o set; fault_cnt_o and sticky_o still update.
REQ-024 Pop condition: evt_valid_o && evt_ready_i; records are returned in capture order.
REQ-025 Simultaneous push and pop: both take effect, and a push to a full FIFO is accepted when a pop occurs in the same cycle.
REQ-026 evt_valid_o=0 when the FIFO is empty; evt_mask_o and evt_time_o are then 0.
REQ-027 Head outputs come directly from registers; a push into an empty FIFO makes evt_valid_o=1 on the next cycle.
REQ-028 Head outputs stay stable while evt_valid_o=1 and evt_ready_i=0.
REQ-029 Per-source run counter: increments while enable_i && faulty_i[i], saturates at PERSIST_THRESH, and clears in any cycle where that condition is false.
REQ-030 persistent_o[i] is set in the cycle after the run counter reaches PERSIST_THRESH, and stays set until clear or reset.
REQ-031 FSM states and transitions:
- IDLE -> MONITOR when enable_i=1.
- MONITOR -> IDLE when enable_i=0.
- MONITOR -> ALARM when any persistent_o bit becomes set.
- ALARM -> IDLE only on clear_i.
REQ-032 Capture continues in ALARM as long as enable_i=1.
REQ-033 enable_i deassertion keeps FIFO contents, counters and sticky flags, and popping still works.
REQ-034 clear_i takes priority over everything else. In the same cycle it:
- empties the FIFO and drops any capture;
- zeroes fault_cnt_o, sticky_o, persistent_o, overflow_o and the run counters;
- sends the FSM to IDLE;
- resets the previous-mask register to 0.

Reset
REQ-035 rst_n low asynchronously forces:
- FSM to IDLE;
- FIFO empty, evt_valid_o=0;
- all output flags and counters, the timestamp, run counters and the previous-mask register to 0.
REQ-036 Reset asserted mid-operation discards all pending records, and no pop handshake completes in that cycle.

Structure
REQ-037 The FSM state enum (IDLE, MONITOR, ALARM) is defined in cv32e40p_pkg.
REQ-038 The event record struct typedef (mask, time) is defined in cv32e40p_pkg.
REQ-039 The FIFO is a sub-module, cv32e40p_tmr_evt_fifo, with push/pop/full/empty ports.

Verification
REQ-040 Bench runs with defaults (4, 4, 16, 3) and covers these directed scenarios:
- Single event: enable=1; faulty_i=0001 for 1 cycle at timestamp 10, reader ready.
  -> one record {0001, 10}; fault_cnt_o=1; sticky_o=0001; persistent_o=0.
- Persistent source: faulty_i=0100 held for 3 cycles.
  -> one record only; persistent_o=0100 and alarm_o=1 one cycle after the third cycle; alarm_o holds until clear_i.
- FIFO full: masks 0001, 0010, 0011, 0100, 1000 on consecutive cycles with evt_ready_i=0.
  -> 4 records retained; overflow_o=1; fault_cnt_o=5.
- Full FIFO with simultaneous push/pop: with evt_ready_i=1, push 1000 in the same cycle.
  -> no overflow; count stays 4; pop order is 0001, 0010, 0011, 0100, then 1000.
- Clear vs. capture: clear_i=1 together with faulty_i=0010.
  -> next cycle evt_valid_o=0 and all flags and counters are 0.
- Mid-operation reset: rst_n pulsed low while 2 records are pending.
  -> evt_valid_o=0 immediately; FSM in IDLE; fault_cnt_o=0.
